// File: rtl/q_8_10_pkg.sv
// Shared types and constants for the q_8_10 state machine and its transition monitor.
package q_8_10_pkg;

  localparam int st_width = 2;

  localparam logic [st_width-1:0] S_0 = 2'd0;
  localparam logic [st_width-1:0] S_1 = 2'd1;
  localparam logic [st_width-1:0] S_2 = 2'd2;
  localparam logic [st_width-1:0] S_3 = 2'd3;

  typedef enum logic [1:0] {
    M_INIT  = 2'd0,
    M_TRACK = 2'd1,
    M_FAULT = 2'd2
  } mon_st_t;

  // Bit [4*from+to] is set when the edge from->to is allowed.
  localparam logic [15:0] LEGAL_TRANS = 16'hDDE3;

  function automatic logic is_legal(input logic [st_width-1:0] from,
                                    input logic [st_width-1:0] to);
    return LEGAL_TRANS[{from, to}];
  endfunction

endpackage

// File: rtl/q_8_10_sat_cnt.sv
// Saturating up-counter with clear, hold and load-one controls (priority in that order).
module q_8_10_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         hold,
  input  logic         load_one,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_next;

  always_comb begin
    q_next = q;
    if (clr)
      q_next = '0;
    else if (hold)
      q_next = q;
    else if (load_one)
      q_next = W'(1);
    else if (inc && (q != {W{1'b1}}))
      q_next = q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      q <= '0;
    else
      q <= q_next;
  end

endmodule

// File: rtl/q_8_10_mon.sv
// Transition monitor for q_8_10: checks edges, counts state entries, tracks dwell,
// and latches the first illegal transition.
module q_8_10_mon
  import q_8_10_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DWELL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [st_width-1:0]   state,
  input  logic                  clr,
  output logic [4*CNT_W-1:0]    visit_cnt,
  output logic [DWELL_W-1:0]    dwell,
  output logic [DWELL_W-1:0]    max_dwell,
  output logic                  err,
  output logic [2*st_width-1:0] err_trans,
  output logic [1:0]            mon_st
);

  mon_st_t               mon_st_reg;
  logic [st_width-1:0]   prev_q;
  logic                  in_init, in_track, changed, illegal, enter;
  logic                  dwell_upd, dwell_inc, dwell_hold;
  logic [DWELL_W-1:0]    dwell_new;

  assign in_init  = (mon_st_reg == M_INIT);
  assign in_track = (mon_st_reg == M_TRACK);
  assign changed  = (state != prev_q);
  assign illegal  = in_track && changed && !is_legal(prev_q, state);
  // A new state is entered on the first sample or on any legal change.
  assign enter    = in_init || (in_track && changed && !illegal);

  assign dwell_inc  = in_track && !changed;
  assign dwell_upd  = in_init || (in_track && !illegal);
  assign dwell_hold = !dwell_upd;

  always_comb begin
    dwell_new = dwell;
    if (enter)
      dwell_new = DWELL_W'(1);
    else if (dwell_inc && (dwell != {DWELL_W{1'b1}}))
      dwell_new = dwell + DWELL_W'(1);
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_visit
      q_8_10_sat_cnt #(.W(CNT_W)) u_visit (
        .clk      (clk),
        .rst_b    (rst_b),
        .clr      (clr),
        .hold     (1'b0),
        .load_one (1'b0),
        .inc      (enter && (state == st_width'(gi))),
        .q        (visit_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  q_8_10_sat_cnt #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr      (clr),
    .hold     (dwell_hold),
    .load_one (enter),
    .inc      (dwell_inc),
    .q        (dwell)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mon_st_reg <= M_INIT;
      prev_q     <= S_0;
      err        <= 1'b0;
      err_trans  <= '0;
      max_dwell  <= '0;
    end else if (clr) begin
      mon_st_reg <= M_INIT;
      prev_q     <= S_0;
      err        <= 1'b0;
      err_trans  <= '0;
      max_dwell  <= '0;
    end else begin
      if (dwell_upd && (dwell_new > max_dwell))
        max_dwell <= dwell_new;
      case (mon_st_reg)
        M_INIT: begin
          prev_q     <= state;
          mon_st_reg <= M_TRACK;
        end
        M_TRACK: begin
          if (illegal) begin
            err        <= 1'b1;
            err_trans  <= {prev_q, state};
            mon_st_reg <= M_FAULT;
          end else begin
            prev_q <= state;
          end
        end
        M_FAULT: ;
        default: mon_st_reg <= M_INIT;
      endcase
    end
  end

  assign mon_st = mon_st_reg;

endmodule

// File: tb/tb_q_8_10_mon.sv
// Self-checking bench for q_8_10_mon: directed scenarios plus randomized walk vs. a reference model.
module tb_q_8_10_mon;
  import q_8_10_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  state = 2'd0;

  logic [31:0] visit_a;
  logic [7:0]  visit_b;
  logic [5:0]  dwell_a, dwell_b, maxd_a, maxd_b;
  logic        err_a, err_b;
  logic [3:0]  et_a, et_b;
  logic [1:0]  mon_a, mon_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_cnt[4];
  int         m_mode;
  int         m_prev;
  int         m_dwell;
  int         m_max;
  bit         m_err;
  logic [3:0] m_et;

  always #5 clk = ~clk;

  q_8_10_mon dut_a (
    .clk(clk), .rst_b(rst_b), .state(state), .clr(clr),
    .visit_cnt(visit_a), .dwell(dwell_a), .max_dwell(maxd_a),
    .err(err_a), .err_trans(et_a), .mon_st(mon_a)
  );

  q_8_10_mon #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_b(rst_b), .state(state), .clr(clr),
    .visit_cnt(visit_b), .dwell(dwell_b), .max_dwell(maxd_b),
    .err(err_b), .err_trans(et_b), .mon_st(mon_b)
  );

  function automatic bit spec_legal(int p, int s);
    if (p == s) return 1'b1;
    return !((p == 0 && (s == 2 || s == 3)) || (p == 1 && s == 0) ||
             (p == 2 && s == 1) || (p == 3 && s == 1));
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_mode = 0; m_prev = 0; m_dwell = 0; m_max = 0; m_err = 1'b0; m_et = 4'd0;
  endtask

  task automatic model_step();
    int s;
    s = int'(state);
    if (clr) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_prev = s; m_cnt[s] = m_cnt[s] + 1; m_dwell = 1;
      if (m_dwell > m_max) m_max = m_dwell;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (s == m_prev) begin
        m_dwell = imin(m_dwell + 1, 63);
        if (m_dwell > m_max) m_max = m_dwell;
      end else if (spec_legal(m_prev, s)) begin
        m_cnt[s] = m_cnt[s] + 1; m_dwell = 1; m_prev = s;
        if (m_dwell > m_max) m_max = m_dwell;
      end else begin
        m_err = 1'b1; m_et = 4'(m_prev * 4 + s); m_mode = 2;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_b) model_reset(); else model_step();
    #1;
  endtask

  task automatic drive(input int s, input bit c);
    state = 2'(s);
    clr = c;
    tick();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    #2;
    checks++;
    if ({visit_a, dwell_a, maxd_a, err_a, et_a, mon_a} !== 51'd0) begin
      errors++;
      $display("FAIL reset_state got %h required 0", {visit_a, dwell_a, maxd_a, err_a, et_a, mon_a});
    end
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_idle_hold();
    repeat (5) drive(0, 1'b0);
    checks++;
    if (visit_a !== 32'h1) begin errors++; $display("FAIL idle_visit got %h required 1", visit_a); end
    checks++;
    if (dwell_a !== 6'd5) begin errors++; $display("FAIL idle_dwell got %0d required 5", dwell_a); end
    checks++;
    if (maxd_a !== 6'd5) begin errors++; $display("FAIL idle_max got %0d required 5", maxd_a); end
    checks++;
    if (err_a !== 1'b0 || mon_a !== 2'd1) begin
      errors++; $display("FAIL idle_ctrl got err=%b mon=%0d required err=0 mon=1", err_a, mon_a);
    end
  endtask

  task automatic test_legal_walk();
    int seq[13] = '{0, 1, 2, 0, 1, 2, 2, 3, 0, 1, 3, 3, 2};
    drive(0, 1'b1);
    foreach (seq[i]) drive(seq[i], 1'b0);
    checks++;
    if (visit_a !== 32'h02030303) begin errors++; $display("FAIL walk_visit got %h required 02030303", visit_a); end
    checks++;
    if (maxd_a !== 6'd2) begin errors++; $display("FAIL walk_max got %0d required 2", maxd_a); end
    checks++;
    if (err_a !== 1'b0 || mon_a !== 2'd1 || dwell_a !== 6'd1) begin
      errors++;
      $display("FAIL walk_ctrl got err=%b mon=%0d dwell=%0d required 0/1/1", err_a, mon_a, dwell_a);
    end
  endtask

  task automatic test_illegal();
    drive(0, 1'b1);
    drive(0, 1'b0);
    drive(2, 1'b0);
    checks++;
    if (err_a !== 1'b1 || et_a !== 4'b0010 || mon_a !== 2'd2) begin
      errors++;
      $display("FAIL illegal_capture got err=%b trans=%b mon=%0d required 1/0010/2", err_a, et_a, mon_a);
    end
    checks++;
    if (visit_a !== 32'h1 || dwell_a !== 6'd1) begin
      errors++; $display("FAIL illegal_counts got visit=%h dwell=%0d required 1/1", visit_a, dwell_a);
    end
    drive(1, 1'b0);
    drive(1, 1'b0);
    checks++;
    if (et_a !== 4'b0010 || err_a !== 1'b1 || mon_a !== 2'd2) begin
      errors++;
      $display("FAIL illegal_keep got trans=%b err=%b mon=%0d required 0010/1/2", et_a, err_a, mon_a);
    end
    checks++;
    if (visit_a !== 32'h1 || dwell_a !== 6'd1 || maxd_a !== 6'd1) begin
      errors++;
      $display("FAIL illegal_frozen got visit=%h dwell=%0d max=%0d required 1/1/1", visit_a, dwell_a, maxd_a);
    end
  endtask

  task automatic test_saturation();
    drive(2, 1'b1);
    repeat (70) drive(2, 1'b0);
    checks++;
    if (dwell_a !== 6'd63 || maxd_a !== 6'd63) begin
      errors++; $display("FAIL sat_dwell got dwell=%0d max=%0d required 63/63", dwell_a, maxd_a);
    end
    drive(2, 1'b0);
    checks++;
    if (dwell_a !== 6'd63 || visit_a !== 32'h00010000) begin
      errors++; $display("FAIL sat_dwell_hold got dwell=%0d visit=%h required 63/00010000", dwell_a, visit_a);
    end
    drive(2, 1'b1);
    repeat (10) begin
      drive(2, 1'b0);
      drive(3, 1'b0);
    end
    checks++;
    if (visit_b !== 8'hF0) begin errors++; $display("FAIL sat_visit_narrow got %h required f0", visit_b); end
    checks++;
    if (visit_a !== 32'h0A0A0000) begin errors++; $display("FAIL sat_visit_wide got %h required 0a0a0000", visit_a); end
  endtask

  task automatic test_clr_priority();
    drive(0, 1'b1);
    drive(1, 1'b0);
    drive(0, 1'b1);
    checks++;
    if (err_a !== 1'b0 || et_a !== 4'd0 || mon_a !== 2'd0) begin
      errors++; $display("FAIL clr_ctrl got err=%b trans=%b mon=%0d required 0/0000/0", err_a, et_a, mon_a);
    end
    checks++;
    if (visit_a !== 32'h0 || dwell_a !== 6'd0 || maxd_a !== 6'd0) begin
      errors++;
      $display("FAIL clr_counts got visit=%h dwell=%0d max=%0d required 0/0/0", visit_a, dwell_a, maxd_a);
    end
    drive(0, 1'b0);
    checks++;
    if (mon_a !== 2'd1 || visit_a !== 32'h1 || dwell_a !== 6'd1) begin
      errors++;
      $display("FAIL clr_resume got mon=%0d visit=%h dwell=%0d required 1/1/1", mon_a, visit_a, dwell_a);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1'b1);
    repeat (4) drive(1, 1'b0);
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({visit_a, visit_b, dwell_a, maxd_a, err_a, et_a, mon_a} !== 59'd0) begin
      errors++;
      $display("FAIL async_reset got visit=%h dwell=%0d max=%0d mon=%0d required all 0",
               visit_a, dwell_a, maxd_a, mon_a);
    end
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    drive(3, 1'b0);
    checks++;
    if (err_a !== 1'b0 || mon_a !== 2'd1 || visit_a !== 32'h01000000 || dwell_a !== 6'd1) begin
      errors++;
      $display("FAIL async_first_sample got err=%b mon=%0d visit=%h dwell=%0d required 0/1/01000000/1",
               err_a, mon_a, visit_a, dwell_a);
    end
  endtask

  task automatic test_random();
    logic [31:0] ev_a;
    logic [7:0]  ev_b;
    int s;
    for (int cyc = 0; cyc < 600; cyc++) begin
      s = $urandom_range(0, 3);
      if ($urandom_range(0, 19) != 0)
        for (int t = 0; t < 20 && !spec_legal(int'(state), s); t++) s = $urandom_range(0, 3);
      drive(s, $urandom_range(0, 39) == 0);
      for (int i = 0; i < 4; i++) begin
        ev_a[i*8 +: 8] = 8'(imin(m_cnt[i], 255));
        ev_b[i*2 +: 2] = 2'(imin(m_cnt[i], 3));
      end
      checks++;
      if (visit_a !== ev_a || visit_b !== ev_b) begin
        errors++;
        $display("FAIL rand_visit cyc %0d got %h/%h required %h/%h", cyc, visit_a, visit_b, ev_a, ev_b);
      end
      checks++;
      if (dwell_a !== 6'(m_dwell) || maxd_a !== 6'(m_max) || dwell_b !== 6'(m_dwell)) begin
        errors++;
        $display("FAIL rand_dwell cyc %0d got %0d/%0d required %0d/%0d", cyc, dwell_a, maxd_a, m_dwell, m_max);
      end
      checks++;
      if (err_a !== m_err || et_a !== m_et || mon_a !== 2'(m_mode) || err_b !== m_err) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d got err=%b trans=%b mon=%0d required %b/%b/%0d",
                 cyc, err_a, et_a, mon_a, m_err, m_et, m_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_legal_walk();
    test_illegal();
    test_saturation();
    test_clr_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_8_10_mon.md
# q_8_10_mon

Transition monitor that sits directly downstream of the q_8_10 state machine and consumes its `state` output. It samples the state every clock and checks each transition against the legal-edge set. It counts entries into each state, tracks current and maximum dwell time, and latches the first illegal transition for debug. It has its own three-state control FSM (INIT/TRACK/FAULT) and is used in benches and on-chip as a health checker.

## Interface
- `CNT_W`, default 8: width of each per-state entry counter; counters saturate.
- `DWELL_W`, default 6: width of the dwell and max-dwell counters; both saturate.
- `clk` in, 1: single clock. All state updates on its rising edge.
- `rst_b` in, 1: reset, asynchronous, active-low.
- `state` in, `st_width`: FSM state being observed (S_0..S_3).
- `clr` in, 1: synchronous clear of counters, error and control FSM.
- `visit_cnt` out, `4*CNT_W`: packed; lane i holds the number of entries into S_i.
- `dwell` out, `DWELL_W`: number of consecutive samples equal to the current state.
- `max_dwell` out, `DWELL_W`: largest `dwell` since reset or clr.
- `err` out, 1: sticky; an illegal transition has been seen.
- `err_trans` out, `2*st_width`: {from, to} of the first illegal transition.
- `mon_st` out, 2: control FSM state (M_INIT=0, M_TRACK=1, M_FAULT=2).

## Operation
- Legal edges: every self-loop, plus S0→S1, S1→S2, S1→S3, S2→S0, S2→S3, S3→S0, S3→S2.
- Illegal edges: S0→S2, S0→S3, S1→S0, S2→S1, S3→S1. The set is held as a package constant, `LEGAL_TRANS[4*from+to]`.
- Internal `prev_q` holds the previous sample.
- M_INIT, entered after reset or clr:
  - The first sample does no legality check.
  - `prev_q` ← `state`.
  - `visit_cnt[state]` += 1.
  - `dwell` ← 1.
  - Next state is M_TRACK.
- M_TRACK, when `state` == `prev_q`:
  - `dwell` ← sat(`dwell`+1).
- M_TRACK, when `state` != `prev_q` and the edge is legal:
  - `visit_cnt[state]` ← sat(+1).
  - `dwell` ← 1.
  - `prev_q` ← `state`.
- M_TRACK, when the edge is illegal:
  - `err` ← 1.
  - `err_trans` ← {`prev_q`, `state`}.
  - Next state is M_FAULT.
  - Counters are not updated on that cycle.
- `max_dwell` ← max(`max_dwell`, next `dwell`) on every M_INIT or M_TRACK update.
- M_FAULT:
  - All counters, `prev_q` and `err_trans` are frozen.
  - Further illegal edges are ignored; the first capture is kept.
  - Exit only by clr or reset.
- clr has top priority over all other updates. On clr: counters, `err` and `err_trans` go to 0, `prev_q` goes to S_0, and the next state is M_INIT. This applies in any state.
- Saturation: counters stop at all-ones and do not wrap.

## Timing
- Reset values: `visit_cnt`=0, `dwell`=0, `max_dwell`=0, `err`=0, `err_trans`=0, `mon_st`=M_INIT, `prev_q`=S_0.
  - Reset applies immediately on `rst_b` falling, independent of `clk`.
- Latency: the FSM changes `state` at edge n. The monitor samples it at edge n+1, and outputs reflect it after edge n+1.
  - Overall: one cycle of lag behind the FSM.
- All outputs are registered. There is no combinational path from `state` to any output.
- Reset released mid-operation: the first edge after release is an M_INIT sample, so no false error is raised from a stale `prev_q`.
- Simultaneous clr and illegal edge: clr wins, and `err` stays 0.

## Structure
- `q_8_10_pkg` gains:
  - `mon_st_t` enum (M_INIT, M_TRACK, M_FAULT).
  - `LEGAL_TRANS` 16-bit constant.
  - Named constants S_0..S_3 if not already present.
  - `st_width` is reused.
- One sub-module: `q_8_10_sat_cnt`.
  - Parameterised width.
  - Inputs: inc, load-one, clear, hold.
  - Instantiated four times for `visit_cnt` and once for `dwell`.

## Test plan
- **Idle hold:** release reset, hold `state`=S_0 for 5 cycles → `visit_cnt[0]`=1, `dwell`=5, `max_dwell`=5, `err`=0, `mon_st`=M_TRACK.
- **Legal walk:** one sample each S0,S1,S2,S0,S1,S2,S2,S3,S0,S1,S3,S3,S2 → `visit_cnt`={3,3,3,2} for S0..S3, `max_dwell`=2, `err`=0.
- **Illegal edge:** drive S0 then S2 → after the next edge `err`=1, `err_trans`={S0,S2}, `mon_st`=M_FAULT.
  - Then drive S2→S1 → `err_trans` is unchanged and counters are frozen.
- **Saturation:** hold S2 for 70 cycles → `dwell`=63 and stays 63.
  - With `CNT_W`=2, toggle S2↔S3 10 times → `visit_cnt[2]`=`visit_cnt[3]`=3.
- **clr priority:** assert clr in the same cycle as an S1→S0 edge → `err`=0, counters 0, `mon_st`=M_INIT, then M_TRACK on the next sample.
- **Async reset mid-run:** drop `rst_b` between clock edges with nonzero counts → all outputs 0 immediately. After release, the first sample does no legality check, even for S3 following a stale S1.
